// File: rtl/config_pkg.sv
// Shared configuration for the operand read-address sequencer: default sizes,
// the latched micro-instruction record and the FSM state encoding.
package config_pkg;

    localparam int DEF_NUM_SRC  = 3;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_MAX_GRP  = 8;
    localparam int DEF_OPCODE_W = 8;
    localparam int DEF_SLOT_W   = (DEF_NUM_SRC > 1) ? $clog2(DEF_NUM_SRC) : 1;
    localparam int DEF_GRP_W    = (DEF_MAX_GRP > 1) ? $clog2(DEF_MAX_GRP) : 1;

    // Field widths follow the package defaults; instances keep their parameters in step.
    typedef struct packed {
        logic [DEF_OPCODE_W-1:0]                opcode;
        logic [DEF_NUM_SRC-1:0][DEF_ADDR_W-1:0] vrs;
        logic [DEF_NUM_SRC-1:0]                 src_en;
        logic [DEF_GRP_W-1:0]                   grp_len;
    } seq_uinstr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        PUSH  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/src_slot_next.sv
// Finds the lowest enabled operand slot strictly above the current slot;
// none_o is raised when no enabled slot remains above it.
module src_slot_next #(
    parameter int NUM_SRC = 3,
    parameter int SLOT_W  = 2
) (
    input  logic [NUM_SRC-1:0] mask_i,
    input  logic [SLOT_W-1:0]  cur_i,
    output logic [SLOT_W-1:0]  next_o,
    output logic               none_o
);

    // Priority search from the top down so the lowest qualifying slot wins.
    always_comb begin
        next_o = '0;
        none_o = 1'b1;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            next_o = (mask_i[i] && (i > int'(cur_i))) ? SLOT_W'(i) : next_o;
            none_o = none_o & ~(mask_i[i] && (i > int'(cur_i)));
        end
    end

endmodule

// File: rtl/operand_addr_seq.sv
// Operand read-address sequencer: latches one micro-instruction, issues a read
// address for every register of every enabled source group, then pushes the opcode.
module operand_addr_seq
    import config_pkg::*;
#(
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_GRP  = DEF_MAX_GRP,
    parameter int OPCODE_W = DEF_OPCODE_W,
    localparam int SLOT_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int GRP_W   = (MAX_GRP > 1) ? $clog2(MAX_GRP) : 1
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                uinstr_valid_i,
    output logic                uinstr_ready_o,
    input  seq_uinstr_t         uinstr_i,
    output logic                rd_addr_valid_o,
    input  logic                rd_addr_ready_i,
    output logic [ADDR_W-1:0]   rd_addr_o,
    output logic [SLOT_W-1:0]   rd_src_o,
    output logic                rd_last_o,
    output logic                op_valid_o,
    input  logic                op_ready_i,
    output logic [OPCODE_W-1:0] op_data_o,
    output logic                busy_o
);

    seq_state_e          state_q, state_d;
    seq_uinstr_t         uinstr_q, uinstr_d;
    logic [SLOT_W-1:0]   s_q, s_d;
    logic [GRP_W-1:0]    k_q, k_d;

    logic                uinstr_ready_q, uinstr_ready_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [SLOT_W-1:0]   rd_src_q, rd_src_d;
    logic                rd_last_q, rd_last_d;
    logic                op_valid_q, op_valid_d;
    logic [OPCODE_W-1:0] op_data_q, op_data_d;
    logic                busy_q, busy_d;

    logic [SLOT_W-1:0]   first_slot_s, next_slot_s, hi_slot_s;
    logic                first_none_s, next_none_s;

    // Slot 0 is tested directly, so the search from slot 0 yields the first slot above it.
    src_slot_next #(
        .NUM_SRC (NUM_SRC),
        .SLOT_W  (SLOT_W)
    ) u_first (
        .mask_i  (uinstr_i.src_en),
        .cur_i   ({SLOT_W{1'b0}}),
        .next_o  (first_slot_s),
        .none_o  (first_none_s)
    );

    src_slot_next #(
        .NUM_SRC (NUM_SRC),
        .SLOT_W  (SLOT_W)
    ) u_next (
        .mask_i  (uinstr_q.src_en),
        .cur_i   (s_q),
        .next_o  (next_slot_s),
        .none_o  (next_none_s)
    );

    // Sequencer next state: accept, walk slots and group registers, push opcode.
    always_comb begin
        state_d  = state_q;
        uinstr_d = uinstr_q;
        s_d      = s_q;
        k_d      = k_q;
        case (state_q)
            IDLE: begin
                if (uinstr_valid_i) begin
                    uinstr_d = uinstr_i;
                    k_d      = '0;
                    if (uinstr_i.src_en[0] || !first_none_s) begin
                        state_d = ISSUE;
                        s_d     = uinstr_i.src_en[0] ? {SLOT_W{1'b0}} : first_slot_s;
                    end else begin
                        state_d = PUSH;
                        s_d     = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (rd_addr_ready_i) begin
                    if (k_q < uinstr_q.grp_len) begin
                        k_d = k_q + GRP_W'(1'b1);
                    end else begin
                        k_d = '0;
                        if (next_none_s) begin
                            state_d = PUSH;
                            s_d     = '0;
                        end else begin
                            s_d = next_slot_s;
                        end
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            PUSH: begin
                if (op_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = PUSH;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                k_d     = '0;
            end
        endcase
    end

    // Highest enabled slot of the instruction held in the next cycle.
    always_comb begin
        hi_slot_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hi_slot_s = uinstr_d.src_en[i] ? SLOT_W'(i) : hi_slot_s;
        end
    end

    // Output values for the next cycle, derived from next state so outputs come straight from flops.
    always_comb begin
        uinstr_ready_d = (state_d == IDLE);
        rd_valid_d     = (state_d == ISSUE);
        op_valid_d     = (state_d == PUSH);
        busy_d         = (state_d != IDLE);
        if (state_d == ISSUE) begin
            rd_addr_d = uinstr_d.vrs[s_d] + ADDR_W'(k_d);
            rd_src_d  = s_d;
            rd_last_d = (k_d == uinstr_d.grp_len) && (s_d == hi_slot_s);
        end else begin
            rd_addr_d = '0;
            rd_src_d  = '0;
            rd_last_d = 1'b0;
        end
        if (state_d == PUSH) begin
            op_data_d = uinstr_d.opcode;
        end else begin
            op_data_d = '0;
        end
    end

    // State, latched instruction, counters and output registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q        <= IDLE;
            uinstr_q       <= '0;
            s_q            <= '0;
            k_q            <= '0;
            uinstr_ready_q <= 1'b1;
            rd_valid_q     <= 1'b0;
            rd_addr_q      <= '0;
            rd_src_q       <= '0;
            rd_last_q      <= 1'b0;
            op_valid_q     <= 1'b0;
            op_data_q      <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            uinstr_q       <= uinstr_d;
            s_q            <= s_d;
            k_q            <= k_d;
            uinstr_ready_q <= uinstr_ready_d;
            rd_valid_q     <= rd_valid_d;
            rd_addr_q      <= rd_addr_d;
            rd_src_q       <= rd_src_d;
            rd_last_q      <= rd_last_d;
            op_valid_q     <= op_valid_d;
            op_data_q      <= op_data_d;
            busy_q         <= busy_d;
        end
    end

    assign uinstr_ready_o  = uinstr_ready_q;
    assign rd_addr_valid_o = rd_valid_q;
    assign rd_addr_o       = rd_addr_q;
    assign rd_src_o        = rd_src_q;
    assign rd_last_o       = rd_last_q;
    assign op_valid_o      = op_valid_q;
    assign op_data_o       = op_data_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_operand_addr_seq.sv
// Self-checking bench for operand_addr_seq: vector table with a scoreboard of
// expected read addresses, plus a hand-written reset-mid-sequence scenario.
module tb_operand_addr_seq;
    import config_pkg::*;

    logic        clk = 1'b0;
    logic        arst_i;
    logic        uinstr_valid_i;
    logic        uinstr_ready_o;
    seq_uinstr_t uinstr_i;
    logic        rd_addr_valid_o;
    logic        rd_addr_ready_i;
    logic [4:0]  rd_addr_o;
    logic [1:0]  rd_src_o;
    logic        rd_last_o;
    logic        op_valid_o;
    logic        op_ready_i;
    logic [7:0]  op_data_o;
    logic        busy_o;

    operand_addr_seq dut (
        .clk_i           (clk),
        .arst_i          (arst_i),
        .uinstr_valid_i  (uinstr_valid_i),
        .uinstr_ready_o  (uinstr_ready_o),
        .uinstr_i        (uinstr_i),
        .rd_addr_valid_o (rd_addr_valid_o),
        .rd_addr_ready_i (rd_addr_ready_i),
        .rd_addr_o       (rd_addr_o),
        .rd_src_o        (rd_src_o),
        .rd_last_o       (rd_last_o),
        .op_valid_o      (op_valid_o),
        .op_ready_i      (op_ready_i),
        .op_data_o       (op_data_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] en;
        logic [4:0] v0, v1, v2;
        logic [2:0] grp;
        logic [7:0] op;
        bit         rnd;
        int         op_stall;
        int         exp_n;
        logic [4:0] exp_first;
        logic [4:0] exp_final;
    } vec_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] src;
        logic       last;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    vec_t    vecs[7];
    int      n_tests = 0;
    int      n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic seq_uinstr_t mk(input vec_t v);
        seq_uinstr_t u;
        u.opcode  = v.op;
        u.vrs[0]  = v.v0;
        u.vrs[1]  = v.v1;
        u.vrs[2]  = v.v2;
        u.src_en  = v.en;
        u.grp_len = v.grp;
        return u;
    endfunction

    // Reference ordering: ascending slot, ascending register, 5-bit wrap.
    task automatic build_exp(input vec_t v);
        logic [4:0] va[3];
        int         hi;
        rd_exp_t    e;
        va[0] = v.v0; va[1] = v.v1; va[2] = v.v2;
        hi = -1;
        for (int i = 0; i < 3; i++) if (v.en[i]) hi = i;
        for (int s = 0; s < 3; s++) begin
            if (v.en[s]) begin
                for (int k = 0; k <= int'(v.grp); k++) begin
                    e.addr = va[s] + 5'(k);
                    e.src  = 2'(s);
                    e.last = (s == hi) && (k == int'(v.grp));
                    sb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic scramble_input();
        logic [31:0] junk;
        junk     = $urandom;
        uinstr_i = junk[$bits(seq_uinstr_t)-1:0];
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!uinstr_ready_o && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check("uinstr_ready_wait", uinstr_ready_o, 1'b1);
    endtask

    task automatic run_instr(input vec_t v);
        int e, n_hs, n_op, stalls, op_wait, first_rd_e, first_op_e, op_hs_e;
        logic rd_held, op_held;
        logic [4:0] h_addr, first_addr, final_addr;
        logic [1:0] h_src;
        logic h_last;
        logic [7:0] h_op;
        rd_exp_t x;

        sb_q.delete();
        build_exp(v);
        wait_ready();
        uinstr_valid_i  = 1'b1;
        uinstr_i        = mk(v);
        rd_addr_ready_i = 1'b0;
        op_ready_i      = 1'b0;
        @(posedge clk); #1;
        uinstr_valid_i = 1'b0;
        scramble_input();

        e = 0; n_hs = 0; n_op = 0; stalls = 0; op_wait = 0;
        first_rd_e = -1; first_op_e = -1; op_hs_e = -1;
        rd_held = 1'b0; op_held = 1'b0;
        first_addr = '0; final_addr = '0; h_addr = '0; h_src = '0; h_last = 1'b0; h_op = '0;
        while (n_op == 0 && e < 300) begin
            rd_addr_ready_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            op_ready_i      = (op_wait >= v.op_stall);
            @(negedge clk);
            check("busy_in_flight", busy_o, 1'b1);
            check("ready_low_in_flight", uinstr_ready_o, 1'b0);
            if (rd_held) begin
                check("rd_valid_held", rd_addr_valid_o, 1'b1);
                check("rd_stable", {rd_addr_o, rd_src_o, rd_last_o}, {h_addr, h_src, h_last});
            end
            if (rd_addr_valid_o) begin
                if (first_rd_e < 0) first_rd_e = e;
                if (rd_addr_ready_i) begin
                    n_hs++;
                    rd_held = 1'b0;
                    if (sb_q.size() == 0) begin
                        check("rd_extra_addr", {rd_addr_o, rd_src_o, rd_last_o}, 8'hFF);
                    end else begin
                        x = sb_q.pop_front();
                        check("rd_addr", rd_addr_o, x.addr);
                        check("rd_src", rd_src_o, x.src);
                        check("rd_last", rd_last_o, x.last);
                        if (n_hs == 1) first_addr = rd_addr_o;
                        final_addr = rd_addr_o;
                    end
                end else begin
                    rd_held = 1'b1;
                    stalls++;
                    h_addr = rd_addr_o; h_src = rd_src_o; h_last = rd_last_o;
                end
            end else begin
                check("rd_fields_zero", {rd_addr_o, rd_src_o, rd_last_o}, 8'h00);
            end
            if (op_held) check("op_stable", {op_valid_o, op_data_o}, {1'b1, h_op});
            if (op_valid_o) begin
                if (first_op_e < 0) first_op_e = e;
                if (op_ready_i) begin
                    n_op++;
                    op_hs_e = e;
                    check("op_data", op_data_o, v.op);
                end else begin
                    op_held = 1'b1;
                    op_wait++;
                    stalls++;
                    h_op = op_data_o;
                end
            end else begin
                check("op_data_zero", op_data_o, 8'h00);
            end
            @(posedge clk); #1;
            e++;
        end
        rd_addr_ready_i = 1'b0;
        op_ready_i      = 1'b0;
        check("op_push_timeout", n_op, 1);
        check("ready_after_push", uinstr_ready_o, 1'b1);
        check("idle_outputs", {busy_o, op_valid_o, rd_addr_valid_o}, 3'b000);
        check("addr_count", n_hs, v.exp_n);
        check("sb_empty", sb_q.size(), 0);
        check("total_cycles", op_hs_e, v.exp_n + stalls);
        if (v.exp_n > 0) begin
            check("first_rd_latency", first_rd_e, 0);
            check("first_addr", first_addr, v.exp_first);
            check("final_addr", final_addr, v.exp_final);
        end else begin
            check("empty_op_latency", first_op_e, 0);
        end
        if (v.op_stall > 0) check("op_stall_cycles", op_wait, v.op_stall);
    endtask

    initial begin
        //          en      v0     v1     v2     grp   op     rnd op_st n  first  final
        vecs[0] = '{3'b001, 5'd4,  5'd0,  5'd0,  3'd0, 8'h12, 0,  0,    1, 5'd4,  5'd4};
        vecs[1] = '{3'b111, 5'd2,  5'd10, 5'd20, 3'd1, 8'hA5, 0,  0,    6, 5'd2,  5'd21};
        vecs[2] = '{3'b101, 5'd30, 5'd15, 5'd7,  3'd3, 8'h3C, 0,  0,    8, 5'd30, 5'd10};
        vecs[3] = '{3'b111, 5'd5,  5'd6,  5'd7,  3'd2, 8'h7E, 1,  5,    9, 5'd5,  5'd9};
        vecs[4] = '{3'b000, 5'd9,  5'd9,  5'd9,  3'd2, 8'h99, 0,  0,    0, 5'd0,  5'd0};
        vecs[5] = '{3'b010, 5'd0,  5'd31, 5'd0,  3'd7, 8'h41, 1,  0,    8, 5'd31, 5'd6};
        vecs[6] = '{3'b110, 5'd1,  5'd12, 5'd3,  3'd0, 8'hC3, 0,  2,    2, 5'd12, 5'd3};

        arst_i          = 1'b1;
        uinstr_valid_i  = 1'b0;
        uinstr_i        = '0;
        rd_addr_ready_i = 1'b0;
        op_ready_i      = 1'b0;
        #2;
        check("reset_ready", uinstr_ready_o, 1'b1);
        check("reset_outputs", {rd_addr_valid_o, rd_addr_o, rd_src_o, rd_last_o, op_valid_o, op_data_o, busy_o},
              20'h0);
        @(posedge clk); #1;
        arst_i = 1'b0;

        for (int i = 0; i < 7; i++) run_instr(vecs[i]);

        // Reset after two of six addresses: everything returns to reset values at once.
        wait_ready();
        uinstr_valid_i  = 1'b1;
        uinstr_i        = mk(vecs[1]);
        @(posedge clk); #1;
        uinstr_valid_i  = 1'b0;
        scramble_input();
        rd_addr_ready_i = 1'b1;
        @(negedge clk);
        check("rst_seq_addr0", {rd_addr_valid_o, rd_addr_o}, {1'b1, 5'd2});
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_seq_addr1", {rd_addr_valid_o, rd_addr_o}, {1'b1, 5'd3});
        @(posedge clk); #1;
        rd_addr_ready_i = 1'b0;
        @(negedge clk);
        check("rst_seq_addr2", {rd_addr_valid_o, rd_addr_o, rd_src_o}, {1'b1, 5'd10, 2'd1});
        #2 arst_i = 1'b1;
        #1;
        check("rst_mid_ready", uinstr_ready_o, 1'b1);
        check("rst_mid_outputs", {rd_addr_valid_o, rd_addr_o, rd_src_o, rd_last_o, op_valid_o, op_data_o, busy_o},
              20'h0);
        @(posedge clk); #1;
        arst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_push", {op_valid_o, rd_addr_valid_o, uinstr_ready_o}, 3'b001);
        end
        @(posedge clk); #1;
        run_instr(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
